mult_seq_32: RTL and testbench
==============================

MULT_SEQ_32 -- requirements
Module: mult_seq_32

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; product width is 2*WIDTH.
REQ-002 Port clock, input, 1: single rising-edge clock for all state.
REQ-003 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 Port start, input, 1: request to begin a multiply; sampled only while ready=1.
REQ-005 Port multiplicand, input, 32: signed two's-complement operand A; sampled with start.
REQ-006 Port multiplier, input, 32: signed two's-complement operand B; sampled with start.
REQ-007 Port ready, output, 1: high when idle and able to accept start.
REQ-008 Port result_valid, output, 1: one-cycle pulse marking a new product.
REQ-009 Port product, output, 64: full signed product A*B.
REQ-010 Port result, output, 32: product[31:0].
REQ-011 Port overflow, output, 1: high when product[63:31] are not all equal, i.e. the product does not fit in 32 signed bits.

Function
REQ-012 FSM states: IDLE, RUN, DONE; ready=1 only in IDLE.
REQ-013 IDLE with start=1 latches the following, clears the accumulator and the count, and enters RUN:
  - |A| zero-extended into a 64-bit multiplicand register;
  - |B| into a 32-bit multiplier register;
  - sign = A[31] XOR B[31].
REQ-014 IDLE with start=0 holds all registers and outputs.
REQ-015 Magnitude of -2^31 is unsigned 2^31; no saturation at latch time.
REQ-016 Each RUN cycle performs these updates:
  - if multiplier_reg[0]=1, acc <= acc + mcand_reg (64-bit, carry discarded);
  - mcand_reg <= mcand_reg shifted left one, bit 0 = 0;
  - multiplier_reg <= multiplier_reg shifted right one, MSB = 0;
  - count <= count + 1.
REQ-017 RUN lasts exactly 32 cycles (count 0..31), then enters DONE; no early termination on zero operands.
REQ-018 DONE performs these updates in one cycle, then returns to IDLE:
  - product <= sign ? (~acc + 1) : acc;
  - overflow is computed from the new product;
  - result_valid=1.
REQ-019 Latency: start accepted on edge T gives result_valid high in the cycle after edge T+33; ready returns high in the same cycle.
REQ-020 A zero product is never negated to a nonzero value: sign with acc=0 yields product=0.
REQ-021 start while ready=0 is ignored; operands are not resampled.
REQ-022 product, result and overflow hold their last value until the next DONE.
REQ-023 start asserted in the cycle result_valid=1 is accepted; back-to-back operation is allowed.

Reset
REQ-024 reset_n=0 at a clock edge forces the following, in any state including mid-RUN:
  - state=IDLE, ready=1, result_valid=0;
  - product=0, overflow=0;
  - acc, mcand_reg, multiplier_reg and count all 0.
REQ-025 An operation in progress when reset is applied is discarded; no result_valid follows.
REQ-026 start is ignored in any cycle where reset_n=0.

Structure
REQ-027 Shared package mult_pkg holds the FSM state enum, WIDTH, PROD_WIDTH=2*WIDTH and COUNT_W=5.
REQ-028 The per-cycle multiplicand shift is a sub-module instance of the team's existing 64-bit shift-left-by-one block (sll_64); no inline shift.
REQ-029 The final negation and the accumulate are plain 64-bit adders inside mult_seq_32; no other sub-modules.

Verification
REQ-030 A=7, B=6, start one cycle -> result_valid exactly 34 cycles later; product=42, result=42, overflow=0.
REQ-031 A=-3, B=5 -> product=0xFFFF_FFFF_FFFF_FFF1 (-15), result=0xFFFF_FFF1, overflow=0.
REQ-032 Edge operands:
  - A=-2^31, B=-2^31 -> product=0x4000_0000_0000_0000, overflow=1;
  - A=-2^31, B=1 -> result=0x8000_0000, overflow=0.
REQ-033 A=0x0001_0000, B=0x0001_0000 -> product=0x1_0000_0000, result=0, overflow=1; A=0, B=-1 -> product=0.
REQ-034 Control boundaries:
  - reset_n=0 at RUN count 10 -> next cycle ready=1, product=0, no result_valid;
  - start pulsed during RUN -> ignored, first result unchanged.
REQ-035 Back-to-back: start re-asserted in the result_valid cycle with A=2, B=3 -> second result_valid 34 cycles later with product=6.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential signed multiplier.
//   WIDTH      - operand width in bits
//   PROD_WIDTH - full product width (2*WIDTH)
//   COUNT_W    - width of the RUN-phase step counter
//   state_t    - FSM state encoding (IDLE, RUN, DONE)
//   mag()      - two's-complement magnitude; the most negative value maps
//                to its unsigned magnitude (2^(WIDTH-1)), never saturated.
package mult_pkg;

    localparam int WIDTH      = 32;
    localparam int PROD_WIDTH = 2 * WIDTH;
    localparam int COUNT_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/sll_64.sv
// sll_64: 64-bit logical shift left by one, purely combinational.
//   d - input word
//   q - d shifted left one place, bit 0 filled with zero
module sll_64 (
    input  logic [63:0] d,
    output logic [63:0] q
);

    assign q[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 64; gi++) begin : g_shift
            assign q[gi] = d[gi-1];
        end
    endgenerate

endmodule

// File: rtl/mult_seq_32.sv
// mult_seq_32: sequential signed multiplier, one shift-add step per cycle.
// Operands are converted to magnitudes at start, multiplied unsigned over
// WIDTH RUN cycles, and the sign is applied in a single DONE cycle.
//   clock        - rising-edge clock
//   reset_n      - synchronous active-low reset
//   start        - begin a multiply (honoured only while ready=1)
//   multiplicand - signed operand A, sampled with start
//   multiplier   - signed operand B, sampled with start
//   ready        - idle and able to accept start
//   result_valid - one-cycle pulse marking a new product
//   product      - full signed product A*B, held until the next result
//   result       - low WIDTH bits of product
//   overflow     - product does not fit in WIDTH signed bits
module mult_seq_32 #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 result_valid,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow
);

    import mult_pkg::*;

    localparam int PROD_W = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN  = 2'(ST_RUN);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    logic [1:0]         state_reg;
    logic [PROD_W-1:0]  acc_reg;
    logic [PROD_W-1:0]  mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               sign_reg;
    logic [PROD_W-1:0]  product_reg;
    logic               overflow_reg;
    logic               result_valid_reg;

    logic [PROD_W-1:0]  mcand_shl;
    logic [PROD_W-1:0]  acc_sum;
    logic [PROD_W-1:0]  acc_neg;
    logic [PROD_W-1:0]  product_next;
    logic [PROD_W-WIDTH:0] upper_bits;
    logic               overflow_next;

    sll_64 u_sll (
        .d (mcand_reg),
        .q (mcand_shl)
    );

    assign acc_sum = acc_reg + mcand_reg;
    // Negating zero yields zero, so a zero magnitude never turns nonzero.
    assign acc_neg = ~acc_reg + PROD_W'(1);
    assign product_next = sign_reg ? acc_neg : acc_reg;

    // Fits in WIDTH signed bits only when the top bits and the result's
    // sign bit are all copies of one another.
    assign upper_bits    = product_next[PROD_W-1:WIDTH-1];
    assign overflow_next = !((&upper_bits) || !(|upper_bits));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg        <= S_IDLE;
            acc_reg          <= '0;
            mcand_reg        <= '0;
            mplier_reg       <= '0;
            count_reg        <= '0;
            sign_reg         <= 1'b0;
            product_reg      <= '0;
            overflow_reg     <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mcand_reg  <= {{(PROD_W-WIDTH){1'b0}}, mag(multiplicand)};
                        mplier_reg <= mag(multiplier);
                        sign_reg   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_sum;
                    end
                    mcand_reg  <= mcand_shl;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + COUNT_W'(1);
                    // Always a full WIDTH steps, even for zero operands.
                    if (count_reg == COUNT_W'(WIDTH - 1)) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    product_reg      <= product_next;
                    overflow_reg     <= overflow_next;
                    result_valid_reg <= 1'b1;
                    state_reg        <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ready        = (state_reg == S_IDLE);
    assign result_valid = result_valid_reg;
    assign product      = product_reg;
    assign result       = product_reg[WIDTH-1:0];
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_mult_seq_32.sv
// tb_mult_seq_32: directed and random checks of mult_seq_32 against a plain
// signed-arithmetic reference model. Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_mult_seq_32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        ready;
    logic        result_valid;
    logic [63:0] product;
    logic [31:0] result;
    logic        overflow;

    int tests  = 0;
    int failed = 0;

    mult_seq_32 dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .result_valid (result_valid),
        .product      (product),
        .result       (result),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle at a falling edge; returns at the falling
    // edge just after the accepting rising edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clock);
        start        = 1'b0;
    endtask

    // Wait (bounded) for result_valid; k0 = edges already elapsed since
    // the accepting edge. Leaves the bench on the result_valid cycle.
    task automatic wait_check(input string tag, input logic [31:0] a,
                              input logic [31:0] b, input int k0);
        int k;
        k = k0;
        while (!result_valid && k < 100) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'd33);
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_product"}, product, ref_prod(a, b));
        check({tag, "_result"}, 64'(result), 64'(ref_prod(a, b) & 64'hFFFF_FFFF));
        check({tag, "_overflow"}, 64'(overflow), 64'(ref_ovf(a, b)));
        $display("[TB] %s A=0x%08h B=0x%08h product=0x%016h ovf=%0b latency=%0d",
                 tag, a, b, product, overflow, k);
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] held;
        start_op(a, b);
        wait_check(tag, a, b, 0);
        held = product;
        @(negedge clock);
        check({tag, "_pulse"}, 64'(result_valid), 64'd0);
        check({tag, "_hold"}, product, held);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;

        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_one("a7_b6", 32'd7, 32'd6);
        run_one("am3_b5", 32'hFFFF_FFFD, 32'd5);
        run_one("min_min", 32'h8000_0000, 32'h8000_0000);
        run_one("min_one", 32'h8000_0000, 32'd1);
        run_one("big_big", 32'h0001_0000, 32'h0001_0000);
        run_one("zero_m1", 32'd0, 32'hFFFF_FFFF);

        // start pulsed with other operands mid-RUN must be ignored
        start_op(32'd1234, 32'hFFFF_FF00);
        repeat (5) @(negedge clock);
        multiplicand = 32'd99;
        multiplier   = 32'd77;
        start        = 1'b1;
        @(negedge clock);
        start        = 1'b0;
        wait_check("start_in_run", 32'd1234, 32'hFFFF_FF00, 6);
        @(negedge clock);

        // back-to-back: restart in the result_valid cycle
        start_op(32'd11, 32'hFFFF_FFF9);
        wait_check("b2b_first", 32'd11, 32'hFFFF_FFF9, 0);
        start_op(32'd2, 32'd3);
        check("b2b_busy", 64'(ready), 64'd0);
        wait_check("b2b_second", 32'd2, 32'd3, 0);
        @(negedge clock);

        // reset while count is 10, with start also high during reset
        start_op(32'd5, 32'd5);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        start   = 1'b1;
        @(negedge clock);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_product", product, 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_valid", 64'(result_valid), 64'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (result_valid || !ready) seen++;
        end
        check("midrst_discarded", 64'(seen), 64'd0);
        $display("[TB] mid-run reset: ready=%0b product=0x%016h", ready, product);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = $urandom_range(0, 255) - 128;
            if (i % 4 == 2) rb = 32'h8000_0000;
            run_one($sformatf("rand%0d", i), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
